axi_mem_arbiter: RTL and testbench

Two-port arbiter that shares the single AXI4 master port of the CPU core between the instruction-fetch unit and the load/store unit. It converts simple valid/ready word requests into single-beat AXI4 transactions (AR/R or AW/W/B), one outstanding at a time, with round-robin arbitration. It sits between the core and the AXI memory slave (the AXI VIP slave memory in simulation, DDR controller on board).

---
 rtl/axi_mem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_axi_mem_arbiter.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_arbiter.sv
// Round-robin arbiter sharing one AXI4 master between fetch and load/store.
// Single-beat transactions, one outstanding at a time.
module axi_mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_req_valid,
    output logic              i_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_resp_valid,
    output logic [31:0]       i_resp_data,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic              d_req_we,
    input  logic [31:0]       d_req_wdata,
    input  logic [3:0]        d_req_wstrb,
    output logic              d_resp_valid,
    output logic [31:0]       d_resp_data,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    input  logic [31:0]       m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [7:0]        m_axi_awlen,
    output logic [2:0]        m_axi_awsize,
    output logic [1:0]        m_axi_awburst,
    output logic [31:0]       m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    output logic              m_axi_wlast,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic              bus_err
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_ADDR = 3'd1;
    localparam logic [2:0] RD_DATA = 3'd2;
    localparam logic [2:0] WR_REQ  = 3'd3;
    localparam logic [2:0] WR_RESP = 3'd4;

    logic [2:0]        state;
    logic              last_d;
    logic              owner_d;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic              aw_done;
    logic              w_done;
    logic              gnt_i;
    logic              gnt_d;
    logic              aw_hs;
    logic              w_hs;
    logic              addr_lsb_unused;

    // On contention the port that did not win last time is served.
    always_comb begin
        gnt_i = (state == IDLE) & i_req_valid
              & (~d_req_valid | last_d);
        gnt_d = (state == IDLE) & d_req_valid
              & (~i_req_valid | ~last_d);
    end

    assign i_req_ready = rstn & gnt_i;
    assign d_req_ready = rstn & gnt_d;

    assign m_axi_araddr  = addr_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_arvalid = (state == RD_ADDR);
    assign m_axi_rready  = (state == RD_DATA);
    assign m_axi_awvalid = (state == WR_REQ) & ~aw_done;
    assign m_axi_wvalid  = (state == WR_REQ) & ~w_done;
    assign m_axi_bready  = (state == WR_RESP);

    assign m_axi_arlen   = 8'd0;
    assign m_axi_awlen   = 8'd0;
    assign m_axi_arsize  = 3'b010;
    assign m_axi_awsize  = 3'b010;
    assign m_axi_arburst = 2'b01;
    assign m_axi_awburst = 2'b01;
    assign m_axi_wlast   = 1'b1;

    assign aw_hs = m_axi_awvalid & m_axi_awready;
    assign w_hs  = m_axi_wvalid & m_axi_wready;
    assign addr_lsb_unused = ^{i_req_addr[1:0], d_req_addr[1:0]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            last_d       <= 1'b1;
            owner_d      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            i_resp_valid <= 1'b0;
            d_resp_valid <= 1'b0;
            i_resp_data  <= '0;
            d_resp_data  <= '0;
            bus_err      <= 1'b0;
        end else begin
            i_resp_valid <= 1'b0;
            d_resp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (gnt_i | gnt_d) begin
                        owner_d <= gnt_d;
                        last_d  <= gnt_d;
                        addr_q  <= gnt_d
                            ? {d_req_addr[ADDR_W-1:2], 2'b00}
                            : {i_req_addr[ADDR_W-1:2], 2'b00};
                        wdata_q <= d_req_wdata;
                        wstrb_q <= d_req_wstrb;
                        state   <= (gnt_d & d_req_we) ? WR_REQ : RD_ADDR;
                    end
                end
                RD_ADDR: begin
                    if (m_axi_arready) state <= RD_DATA;
                end
                RD_DATA: begin
                    if (m_axi_rvalid) begin
                        if (owner_d) begin
                            d_resp_data  <= m_axi_rdata;
                            d_resp_valid <= 1'b1;
                        end else begin
                            i_resp_data  <= m_axi_rdata;
                            i_resp_valid <= 1'b1;
                        end
                        if (m_axi_rresp != 2'b00) bus_err <= 1'b1;
                        state <= IDLE;
                    end
                end
                WR_REQ: begin
                    // AW and W complete independently, in any order.
                    if ((aw_done | aw_hs) & (w_done | w_hs)) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= WR_RESP;
                    end else begin
                        if (aw_hs) aw_done <= 1'b1;
                        if (w_hs)  w_done  <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (m_axi_bvalid) begin
                        d_resp_valid <= 1'b1;
                        if (m_axi_bresp != 2'b00) bus_err <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Randomized scoreboard bench for axi_mem_arbiter with a behavioural
// AXI slave memory and a reference memory model.
module tb_axi_mem_arbiter;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic        i_req_valid, i_req_ready, i_resp_valid;
    logic [31:0] i_req_addr, i_resp_data;
    logic        d_req_valid, d_req_ready, d_req_we, d_resp_valid;
    logic [31:0] d_req_addr, d_req_wdata, d_resp_data;
    logic [3:0]  d_req_wstrb;
    logic [31:0] m_axi_araddr, m_axi_rdata, m_axi_awaddr, m_axi_wdata;
    logic        m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic        m_axi_wlast, m_axi_bvalid, m_axi_bready, bus_err;
    logic [7:0]  m_axi_arlen, m_axi_awlen;
    logic [2:0]  m_axi_arsize, m_axi_awsize;
    logic [1:0]  m_axi_arburst, m_axi_awburst, m_axi_rresp, m_axi_bresp;
    logic [3:0]  m_axi_wstrb;

    axi_mem_arbiter #(.ADDR_W(32)) dut (
        .clk(clk), .rstn(rstn),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready),
        .i_req_addr(i_req_addr), .i_resp_valid(i_resp_valid),
        .i_resp_data(i_resp_data),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready),
        .d_req_addr(d_req_addr), .d_req_we(d_req_we),
        .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb),
        .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_wlast(m_axi_wlast), .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .bus_err(bus_err)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] data;
    } dexp_t;

    int tot = 0;
    int bad = 0;
    int cyc = 0;
    logic [31:0] rmem [logic [31:0]];
    logic [31:0] smem [logic [31:0]];
    logic [31:0] iq [$];
    dexp_t       dq [$];
    logic [31:0] arq [$];
    logic [31:0] awq [$];
    logic [35:0] wq [$];
    int          gseq [$];
    logic [31:0] i_last = '0;
    logic [31:0] d_last = '0;
    logic        exp_err = 1'b0;
    int          last_g = 1;
    int          grant_cyc = 0;
    int          iresp_cyc = 0;
    int          i_cnt = 0;
    int          d_cnt = 0;

    bit cfg_rnd = 0, cfg_skew = 0, cfg_err = 0, cfg_berr = 0;
    int lat_min = 0, lat_max = 0;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [31:0] k);
        return {k[15:0] ^ 16'hA5C3, ~k[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o,
            input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] k);
        return rmem.exists(k) ? rmem[k] : init_val(k);
    endfunction

    function automatic logic [31:0] slv_rd(input logic [31:0] k);
        return smem.exists(k) ? smem[k] : init_val(k);
    endfunction

    task automatic fetch_req(input logic [31:0] a);
        int n;
        logic [31:0] k;
        n = 0;
        k = {a[31:2], 2'b00};
        @(negedge clk);
        i_req_valid = 1'b1;
        i_req_addr = a;
        #1;
        while (!i_req_ready && n < 500) begin
            @(negedge clk); #1; n++;
        end
        if (!i_req_ready) begin
            tot++; bad++;
            $display("FAIL fetch_grant: addr %h not accepted in 500 cycles", a);
        end else begin
            iq.push_back(ref_rd(k));
            arq.push_back(k);
        end
        @(posedge clk); #1;
        i_req_valid = 1'b0;
    endtask

    task automatic data_req(input logic [31:0] a, input logic we,
            input logic [31:0] wd, input logic [3:0] ws);
        int n;
        logic [31:0] k;
        n = 0;
        k = {a[31:2], 2'b00};
        @(negedge clk);
        d_req_valid = 1'b1;
        d_req_addr = a;
        d_req_we = we;
        d_req_wdata = wd;
        d_req_wstrb = ws;
        #1;
        while (!d_req_ready && n < 500) begin
            @(negedge clk); #1; n++;
        end
        if (!d_req_ready) begin
            tot++; bad++;
            $display("FAIL data_grant: addr %h not accepted in 500 cycles", a);
        end else if (we) begin
            rmem[k] = merge(ref_rd(k), wd, ws);
            dq.push_back('{1'b1, 32'h0});
            awq.push_back(k);
            wq.push_back({ws, wd});
        end else begin
            dq.push_back('{1'b0, ref_rd(k)});
            arq.push_back(k);
        end
        @(posedge clk); #1;
        d_req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        while ((iq.size() != 0 || dq.size() != 0) && n < maxc) begin
            @(negedge clk); n++;
        end
        if (iq.size() != 0 || dq.size() != 0) begin
            tot++; bad++;
            $display("FAIL drain: %0d fetch and %0d data responses missing",
                     iq.size(), dq.size());
        end
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
        a[1:0] = 2'($urandom_range(0, 3));
        return a;
    endfunction

    // Behavioural slave; handshakes seen at one negedge land at the next posedge.
    bit ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic [31:0] c_ar, c_aw, c_wd;
    logic [3:0]  c_ws;
    logic [1:0]  c_rresp, c_bresp;
    bit rd_pend, aw_got, w_got, b_pend;
    int rd_cnt, b_cnt, aw_wait;
    logic [31:0] rd_a, wa, wdd;
    logic [3:0]  wss;
    logic [35:0] wexp;

    initial begin
        m_axi_arready = 1'b1; m_axi_awready = 1'b1; m_axi_wready = 1'b1;
        m_axi_rvalid = 1'b0; m_axi_bvalid = 1'b0;
        m_axi_rdata = '0; m_axi_rresp = '0; m_axi_bresp = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                m_axi_rvalid = 1'b0; m_axi_bvalid = 1'b0;
                m_axi_rresp = '0; m_axi_bresp = '0;
                m_axi_arready = 1'b1; m_axi_wready = 1'b1;
                m_axi_awready = !cfg_skew;
                rd_pend = 0; aw_got = 0; w_got = 0; b_pend = 0; aw_wait = 0;
            end else begin
                if (ar_hs) begin
                    if (arq.size() == 0) chk("ar_unexpected", c_ar, 32'hFFFF_FFFF);
                    else chk("araddr", c_ar, arq.pop_front());
                    rd_a = c_ar; rd_pend = 1;
                    rd_cnt = $urandom_range(lat_min, lat_max);
                end
                if (r_hs) begin
                    m_axi_rvalid = 1'b0;
                    if (c_rresp != 2'b00) exp_err = 1'b1;
                end
                if (aw_hs) begin
                    if (cfg_skew) chk("w_before_aw", 32'(w_got), 1);
                    if (awq.size() == 0) chk("aw_unexpected", c_aw, 32'hFFFF_FFFF);
                    else chk("awaddr", c_aw, awq.pop_front());
                    wa = c_aw; aw_got = 1;
                end
                if (w_hs) begin
                    if (wq.size() == 0) chk("w_unexpected", c_wd, 32'hFFFF_FFFF);
                    else begin
                        wexp = wq.pop_front();
                        chk("wdata", c_wd, wexp[31:0]);
                        chk("wstrb", 32'(c_ws), 32'(wexp[35:32]));
                    end
                    wdd = c_wd; wss = c_ws; w_got = 1;
                end
                if (b_hs) begin
                    m_axi_bvalid = 1'b0;
                    if (c_bresp != 2'b00) exp_err = 1'b1;
                end
                if (aw_got && w_got) begin
                    smem[wa] = merge(slv_rd(wa), wdd, wss);
                    aw_got = 0; w_got = 0; b_pend = 1;
                    b_cnt = $urandom_range(lat_min, lat_max);
                end
                if (rd_pend) begin
                    if (rd_cnt == 0) begin
                        m_axi_rvalid = 1'b1;
                        m_axi_rdata = slv_rd(rd_a);
                        m_axi_rresp = (cfg_err && $urandom_range(0, 15) == 0)
                                    ? 2'b10 : 2'b00;
                        rd_pend = 0;
                    end else rd_cnt--;
                end
                if (b_pend) begin
                    if (b_cnt == 0) begin
                        m_axi_bvalid = 1'b1;
                        m_axi_bresp = (cfg_berr ||
                            (cfg_err && $urandom_range(0, 15) == 0))
                            ? 2'b10 : 2'b00;
                        cfg_berr = 0; b_pend = 0;
                    end else b_cnt--;
                end
                m_axi_arready = cfg_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                m_axi_wready  = cfg_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (cfg_skew) begin
                    if (aw_hs) aw_wait = 0;
                    else if (m_axi_awvalid) aw_wait++;
                    m_axi_awready = (aw_wait >= 3);
                end else begin
                    m_axi_awready = cfg_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                end
            end
            ar_hs = rstn && m_axi_arvalid && m_axi_arready;
            r_hs  = rstn && m_axi_rvalid && m_axi_rready;
            aw_hs = rstn && m_axi_awvalid && m_axi_awready;
            w_hs  = rstn && m_axi_wvalid && m_axi_wready;
            b_hs  = rstn && m_axi_bvalid && m_axi_bready;
            c_ar = m_axi_araddr; c_aw = m_axi_awaddr;
            c_wd = m_axi_wdata; c_ws = m_axi_wstrb;
            c_rresp = m_axi_rresp; c_bresp = m_axi_bresp;
        end
    end

    // Arbitration monitor
    initial forever begin
        int g;
        @(negedge clk); #2;
        if (rstn && (i_req_ready || d_req_ready)) begin
            chk("single_grant", 32'(i_req_ready && d_req_ready), 0);
            g = d_req_ready ? 1 : 0;
            if (i_req_valid && d_req_valid)
                chk("rr_grant", 32'(g), (last_g == 1) ? 0 : 1);
            else
                chk("grant_valid", 32'(g ? d_req_valid : i_req_valid), 1);
            gseq.push_back(g);
            last_g = g;
            grant_cyc = cyc;
        end
    end

    // Response monitor
    initial forever begin
        dexp_t e;
        @(negedge clk); #2;
        if (rstn) begin
            if (i_resp_valid) begin
                if (iq.size() == 0) chk("i_resp_unexpected", i_resp_data, 32'hX);
                else begin
                    i_last = iq.pop_front();
                    chk("i_resp_data", i_resp_data, i_last);
                    chk("bus_err_i", 32'(bus_err), 32'(exp_err));
                end
                i_cnt++; iresp_cyc = cyc;
            end else chk("i_resp_hold", i_resp_data, i_last);
            if (d_resp_valid) begin
                if (dq.size() == 0) chk("d_resp_unexpected", d_resp_data, 32'hX);
                else begin
                    e = dq.pop_front();
                    if (!e.we) d_last = e.data;
                    chk("d_resp_data", d_resp_data, d_last);
                    chk("bus_err_d", 32'(bus_err), 32'(exp_err));
                end
                d_cnt++;
            end else chk("d_resp_hold", d_resp_data, d_last);
        end
    end

    initial begin
        logic [31:0] w, iv;
        int n, ic0, dc0;
        i_req_valid = 0; i_req_addr = '0;
        d_req_valid = 0; d_req_addr = '0; d_req_we = 0;
        d_req_wdata = '0; d_req_wstrb = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_arvalid", 32'(m_axi_arvalid), 0);
        chk("rst_awvalid", 32'(m_axi_awvalid), 0);
        chk("rst_wvalid", 32'(m_axi_wvalid), 0);
        chk("rst_rready", 32'(m_axi_rready), 0);
        chk("rst_bready", 32'(m_axi_bready), 0);
        chk("rst_resp_valid", 32'({i_resp_valid, d_resp_valid}), 0);
        chk("rst_i_data", i_resp_data, 0);
        chk("rst_d_data", d_resp_data, 0);
        chk("rst_bus_err", 32'(bus_err), 0);
        chk("axlen", 32'({m_axi_arlen, m_axi_awlen}), 0);
        chk("axsize", 32'({m_axi_arsize, m_axi_awsize}), 32'h12);
        chk("axburst_wlast", 32'({m_axi_arburst, m_axi_awburst, m_axi_wlast}), 32'h0B);
        @(negedge clk);
        rstn = 1'b1;

        // Contention from reset: expected order I, D, I, D
        gseq.delete();
        fork
            fetch_req(32'h2000);
            data_req(32'h2040, 1'b0, 32'h0, 4'h0);
        join
        fork
            fetch_req(32'h2004);
            data_req(32'h2044, 1'b0, 32'h0, 4'h0);
        join
        wait_idle(200);
        chk("contention_count", 32'(gseq.size()), 4);
        for (int j = 0; j < 4 && j < gseq.size(); j++)
            chk("contention_order", 32'(gseq[j]), 32'(j % 2));

        // Zero-wait fetch and its latency, then an unaligned fetch
        rmem[32'h104] = 32'hDEADBEEF;
        smem[32'h104] = 32'hDEADBEEF;
        ic0 = i_cnt; dc0 = d_cnt;
        fetch_req(32'h0000_0104);
        wait_idle(50);
        chk("fetch_cnt", 32'(i_cnt - ic0), 1);
        chk("fetch_latency", 32'(iresp_cyc - grant_cyc), 3);
        chk("fetch_no_d", 32'(d_cnt - dc0), 0);
        chk("fetch_data", i_resp_data, 32'hDEADBEEF);
        fetch_req(32'h0000_0107);
        wait_idle(50);
        chk("unaligned_data", i_resp_data, 32'hDEADBEEF);

        // Write with AW delayed behind W
        cfg_skew = 1;
        dc0 = d_cnt;
        data_req(32'h200, 1'b1, 32'h12345678, 4'b0011);
        wait_idle(100);
        cfg_skew = 0;
        chk("skew_resp_cnt", 32'(d_cnt - dc0), 1);
        w = smem[32'h200];
        iv = init_val(32'h200);
        chk("mem_200_lo", {16'h0, w[15:0]}, 32'h5678);
        chk("mem_200_hi", {16'h0, w[31:16]}, {16'h0, iv[31:16]});
        data_req(32'h200, 1'b0, 32'h0, 4'h0);
        wait_idle(50);

        // Error response, then OKAY traffic keeps bus_err set
        cfg_berr = 1;
        data_req(32'h300, 1'b1, 32'hCAFEF00D, 4'hF);
        wait_idle(50);
        fetch_req(32'h300);
        data_req(32'h300, 1'b0, 32'h0, 4'h0);
        wait_idle(50);
        chk("bus_err_sticky", 32'(bus_err), 1);

        // Randomized concurrent traffic
        cfg_rnd = 1; cfg_err = 1; lat_min = 0; lat_max = 3;
        fork
            repeat (60) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                fetch_req(rand_addr());
            end
            repeat (60) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                data_req(rand_addr(), 1'($urandom_range(0, 1)),
                         $urandom, 4'($urandom_range(0, 15)));
            end
        join
        wait_idle(500);
        cfg_rnd = 0; cfg_err = 0;

        // Reset while a read response is pending
        lat_min = 10; lat_max = 10;
        fetch_req(32'h1040);
        n = 0;
        while (!m_axi_rready && n < 50) begin
            @(negedge clk); n++;
        end
        chk("reached_rd_data", 32'(m_axi_rready), 1);
        @(negedge clk);
        rstn = 1'b0;
        iq.delete(); dq.delete(); arq.delete(); awq.delete(); wq.delete();
        i_last = '0; d_last = '0; exp_err = 1'b0; last_g = 1;
        #1;
        chk("mid_rst_arvalid", 32'(m_axi_arvalid), 0);
        chk("mid_rst_rready", 32'(m_axi_rready), 0);
        chk("mid_rst_resp", 32'({i_resp_valid, d_resp_valid}), 0);
        chk("mid_rst_bus_err", 32'(bus_err), 0);
        lat_min = 0; lat_max = 0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        ic0 = i_cnt;
        fetch_req(32'h1044);
        wait_idle(50);
        chk("post_rst_fetch", 32'(i_cnt - ic0), 1);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
